clock_tick_bank: RTL and testbench

CLOCK_TICK_BANK -- requirements
Module: clock_tick_bank

---
 rtl/clock_tick_bank.sv | 98 +++++++++
 tb/tb_clock_tick_bank.sv | 168 ++++++++++++++++
 2 files changed

// File: rtl/clock_tick_bank.sv
// clock_tick_bank: a bank of independent programmable tick dividers.
// Each channel counts MasterClock cycles and issues a one-cycle Tick every Div
// cycles, plus a Square output that toggles on every Tick. New divisors
// arrive through a one-deep pending slot. A pending divisor is applied on the
// target channel's wrap edge so that no period is ever truncated. If that
// channel is not counting, the divisor is applied on the next edge instead.
module clock_tick_bank #(
    parameter  int NUM_CH      = 4,
    parameter  int CNT_W       = 26,
    parameter  int DEFAULT_DIV = 50000000,
    localparam int CH_W        = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
    input  logic              MasterClock,
    input  logic              Reset,
    input  logic [NUM_CH-1:0] Enable,
    input  logic              LoadValid,
    input  logic [CH_W-1:0]   LoadCh,
    input  logic [CNT_W-1:0]  LoadDiv,
    output logic              LoadReady,
    output logic [NUM_CH-1:0] Tick,
    output logic [NUM_CH-1:0] Square
);

    // One extra bit so that channel indices and NUM_CH compare without overflow.
    localparam int               CHX_W  = CH_W + 1;
    localparam logic [CHX_W-1:0] L_NCH  = CHX_W'(NUM_CH);
    localparam logic [CNT_W-1:0] L_DDIV = CNT_W'(DEFAULT_DIV);

    logic              r_pend_vld;
    logic [CH_W-1:0]   r_pend_ch;
    logic [CNT_W-1:0]  r_pend_div;
    logic [CHX_W-1:0]  w_pend_chx;
    logic [NUM_CH-1:0] w_apply;
    logic              w_drop;

    assign w_pend_chx = {1'b0, r_pend_ch};
    // A pending load aimed past the last channel is retired on the next edge.
    assign w_drop     = r_pend_vld && (w_pend_chx >= L_NCH);
    assign LoadReady  = !r_pend_vld;

    // The pending slot is filled by an accepted request and freed on its apply edge.
    always_ff @(posedge MasterClock or posedge Reset) begin
        if (Reset) begin
            r_pend_vld <= 1'b0;
            r_pend_ch  <= '0;
            r_pend_div <= '0;
        end else if (r_pend_vld) begin
            if ((|w_apply) || w_drop) begin
                r_pend_vld <= 1'b0;
            end
        end else if (LoadValid) begin
            r_pend_vld <= 1'b1;
            r_pend_ch  <= LoadCh;
            r_pend_div <= LoadDiv;
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
        logic [CNT_W-1:0] r_div;
        logic [CNT_W-1:0] r_cnt;
        logic             r_tick;
        logic             r_sq;
        logic             w_run;
        logic             w_wrap;

        assign w_run      = Enable[g] && (r_div != '0);
        assign w_wrap     = w_run && (r_cnt == (r_div - CNT_W'(1)));
        // Apply at the wrap when counting, otherwise immediately.
        assign w_apply[g] = r_pend_vld && (w_pend_chx == CHX_W'(g)) && (w_wrap || !w_run);

        // Channel counter, divisor, tick pulse and square wave.
        always_ff @(posedge MasterClock or posedge Reset) begin
            if (Reset) begin
                r_div  <= L_DDIV;
                r_cnt  <= '0;
                r_tick <= 1'b0;
                r_sq   <= 1'b0;
            end else begin
                r_tick <= w_wrap;
                if (w_wrap) begin
                    r_sq <= ~r_sq;
                end
                if (w_apply[g]) begin
                    r_div <= r_pend_div;
                    r_cnt <= '0;
                end else if (w_run) begin
                    r_cnt <= w_wrap ? '0 : r_cnt + CNT_W'(1);
                end else if (r_div == '0) begin
                    r_cnt <= '0;
                end
            end
        end

        assign Tick[g]   = r_tick;
        assign Square[g] = r_sq;
    end

endmodule

// File: tb/tb_clock_tick_bank.sv
// Testbench for clock_tick_bank: randomized enables and loads checked every
// cycle against a behavioural model that tracks cycles-to-next-tick per channel.
module tb_clock_tick_bank;

    localparam int NCH  = 5;
    localparam int CW   = 8;
    localparam int DDIV = 4;

    logic           clk = 1'b0;
    logic           rst;
    logic [NCH-1:0] en;
    logic           lv;
    logic [2:0]     lch;
    logic [CW-1:0]  ldiv;
    logic           ready;
    logic [NCH-1:0] tick;
    logic [NCH-1:0] sq;

    int n_vec = 0;
    int n_err = 0;

    // Model state: divisor, cycles left until the next tick, outputs, pending slot.
    int             m_div  [NCH];
    int             m_left [NCH];
    bit [NCH-1:0]   m_tick;
    bit [NCH-1:0]   m_sq;
    bit             m_pv;
    int             m_pc;
    int             m_pd;

    clock_tick_bank #(.NUM_CH(NCH), .CNT_W(CW), .DEFAULT_DIV(DDIV)) dut (
        .MasterClock (clk),
        .Reset       (rst),
        .Enable      (en),
        .LoadValid   (lv),
        .LoadCh      (lch),
        .LoadDiv     (ldiv),
        .LoadReady   (ready),
        .Tick        (tick),
        .Square      (sq)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_div[i]  = DDIV;
            m_left[i] = DDIV;
        end
        m_tick = '0;
        m_sq   = '0;
        m_pv   = 1'b0;
        m_pc   = 0;
        m_pd   = 0;
    endtask

    // One clock edge of the specified behaviour, given the inputs present before it.
    task automatic model_step(input logic [NCH-1:0] e, input logic v, input int c, input int d);
        bit any_app;
        any_app = 1'b0;
        for (int i = 0; i < NCH; i++) begin
            bit w;
            bit a;
            w = e[i] && (m_div[i] > 0) && (m_left[i] == 1);
            a = m_pv && (m_pc == i) && (w || !e[i] || m_div[i] == 0);
            m_tick[i] = w;
            if (w) m_sq[i] = ~m_sq[i];
            if (a) begin
                m_div[i]  = m_pd;
                m_left[i] = m_pd;
                any_app   = 1'b1;
            end else if (e[i] && m_div[i] > 0) begin
                m_left[i] = w ? m_div[i] : m_left[i] - 1;
            end
        end
        if (m_pv) begin
            if (any_app || m_pc >= NCH) m_pv = 1'b0;
        end else if (v) begin
            m_pv = 1'b1;
            m_pc = c;
            m_pd = d;
        end
    endtask

    // Called at a falling edge: drive, advance model, check after the rising edge.
    task automatic cycle(input logic [NCH-1:0] e, input logic v, input logic [2:0] c, input logic [CW-1:0] d);
        en   = e;
        lv   = v;
        lch  = c;
        ldiv = d;
        model_step(e, v, int'(c), int'(d));
        @(posedge clk);
        #1;
        check("tick",  32'(tick),  32'(m_tick));
        check("square", 32'(sq),   32'(m_sq));
        check("ready", 32'(ready), 32'(!m_pv));
        @(negedge clk);
    endtask

    initial begin
        logic [NCH-1:0] re;
        rst  = 1'b1;
        en   = '1;
        lv   = 1'b0;
        lch  = '0;
        ldiv = '0;
        model_reset();
        #1;
        check("rst_tick",  32'(tick),  32'(0));
        check("rst_square", 32'(sq),   32'(0));
        check("rst_ready", 32'(ready), 32'(1));
        @(negedge clk);
        rst = 1'b0;

        // Default divisor of 4 from reset: ticks on edges 4, 8, 12.
        for (int k = 1; k <= 12; k++) begin
            cycle('1, 1'b0, 3'd0, '0);
            check("t0_default", 32'(tick[0]), 32'((k % 4) == 0));
        end

        // Out-of-range load, then a second request while the slot is busy.
        cycle('1, 1'b1, 3'd5, 8'd2);
        cycle('1, 1'b1, 3'd1, 8'd2);
        for (int k = 0; k < 6; k++) cycle('1, 1'b0, 3'd0, '0);

        // Randomized enables and loads.
        for (int k = 0; k < 400; k++) begin
            for (int i = 0; i < NCH; i++) re[i] = ($urandom_range(0, 9) != 0);
            cycle(re, ($urandom_range(0, 3) == 0), 3'($urandom_range(0, 7)), CW'($urandom_range(0, 6)));
        end

        // Drain the slot, queue a load, then reset asynchronously mid-cycle.
        for (int k = 0; k < 40 && m_pv; k++) cycle('1, 1'b0, 3'd0, '0);
        cycle('1, 1'b1, 3'd2, 8'd7);
        #2;
        rst = 1'b1;
        #1;
        check("async_tick",  32'(tick),  32'(0));
        check("async_square", 32'(sq),   32'(0));
        check("async_ready", 32'(ready), 32'(1));
        model_reset();
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        for (int k = 1; k <= 12; k++) begin
            cycle('1, 1'b0, 3'd0, '0);
            check("t_post_rst", 32'(tick), 32'((k % 4) == 0 ? {NCH{1'b1}} : '0));
        end

        // More randomized traffic after the reset.
        for (int k = 0; k < 300; k++) begin
            for (int i = 0; i < NCH; i++) re[i] = ($urandom_range(0, 7) != 0);
            cycle(re, ($urandom_range(0, 2) == 0), 3'($urandom_range(0, 7)), CW'($urandom_range(0, 5)));
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
